// File: rtl/custom_axi_ip_pkg.sv
// Shared types for the command engine: FSM status encoding and command opcodes.
// No logic here; status values are what register readback reports.
package custom_axi_ip_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DONE  = 2'd2,
    ERROR = 2'd3
  } status_e;

  typedef enum logic [1:0] {
    OP_PASS = 2'd0,
    OP_ACC  = 2'd1,
    OP_CLR  = 2'd2,
    OP_RSVD = 2'd3
  } op_e;

  localparam int OP_W = 2;

endpackage

// File: rtl/custom_axi_ip_fifo.sv
// Command FIFO: 1-cycle write-to-visible latency, pop data is the combinational head.
// Backpressure: push ignored when full, pop ignored when empty, flush empties in one edge.
module custom_axi_ip_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/custom_axi_ip_engine.sv
// Buffered opcode engine: result valid OP_LATENCY+1 edges after the input handshake.
// Backpressure: in_ready_o drops when the FIFO is full; DONE holds its result until out_ready_i.
module custom_axi_ip_engine
  import custom_axi_ip_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int OP_LATENCY = 2,
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [1:0]            in_op_i,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  out_ovf_o,
  input  logic                  clear_i,
  output logic [1:0]            status_o,
  output logic [LVL_W-1:0]      fifo_level_o,
  output logic                  err_o
);

  localparam int CNT_W = (OP_LATENCY > 1) ? $clog2(OP_LATENCY) : 1;
  localparam int ENT_W = OP_W + DATA_WIDTH;

  status_e               state;
  logic [CNT_W-1:0]      busy_cnt;
  logic [DATA_WIDTH-1:0] acc;
  op_e                   cur_op;
  logic [DATA_WIDTH-1:0] cur_data;
  logic [DATA_WIDTH:0]   acc_sum;

  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic [ENT_W-1:0]      fifo_head;
  op_e                   head_op;
  logic [DATA_WIDTH-1:0] head_data;

  assign in_ready_o = !fifo_full;
  assign fifo_push  = in_valid_i && !fifo_full && !clear_i;
  assign fifo_pop   = (state == IDLE) && !fifo_empty && !clear_i;
  assign head_op    = op_e'(fifo_head[ENT_W-1:DATA_WIDTH]);
  assign head_data  = fifo_head[DATA_WIDTH-1:0];
  assign acc_sum    = {1'b0, acc} + {1'b0, cur_data};
  assign status_o   = state;

  custom_axi_ip_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (LVL_W)
  ) u_fifo (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .flush     (clear_i),
    .push      (fifo_push),
    .push_data ({in_op_i, in_data_i}),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_level_o)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      busy_cnt    <= '0;
      acc         <= '0;
      cur_op      <= OP_PASS;
      cur_data    <= '0;
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_ovf_o   <= 1'b0;
      err_o       <= 1'b0;
    end else if (clear_i) begin
      // Abort wins over any in-flight execute or pending result.
      state       <= IDLE;
      busy_cnt    <= '0;
      acc         <= '0;
      out_valid_o <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            cur_op   <= head_op;
            cur_data <= head_data;
            busy_cnt <= '0;
            state    <= (head_op == OP_RSVD) ? ERROR : BUSY;
          end
        end
        BUSY: begin
          if (busy_cnt == CNT_W'(OP_LATENCY - 1)) begin
            state       <= DONE;
            out_valid_o <= 1'b1;
            case (cur_op)
              OP_ACC: begin
                acc        <= acc_sum[DATA_WIDTH-1:0];
                out_data_o <= acc_sum[DATA_WIDTH-1:0];
                out_ovf_o  <= acc_sum[DATA_WIDTH];
              end
              OP_CLR: begin
                acc        <= '0;
                out_data_o <= '0;
                out_ovf_o  <= 1'b0;
              end
              default: begin
                out_data_o <= cur_data;
                out_ovf_o  <= 1'b0;
              end
            endcase
          end else begin
            busy_cnt <= busy_cnt + CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready_i) begin
            out_valid_o <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          err_o <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_custom_axi_ip_engine.sv
// Directed bench for custom_axi_ip_engine with default parameters (32-bit, depth 4, latency 2).
module tb_custom_axi_ip_engine;

  localparam int DW = 32;
  localparam int LW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    in_op = 2'd0;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_ovf;
  logic          clear = 1'b0;
  logic [1:0]    status;
  logic [LW-1:0] level;
  logic          err;

  int tests = 0;
  int fails = 0;

  custom_axi_ip_engine dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_op_i      (in_op),
    .in_data_i    (in_data),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_data_o   (out_data),
    .out_ovf_o    (out_ovf),
    .clear_i      (clear),
    .status_o     (status),
    .fifo_level_o (level),
    .err_o        (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] op, input logic [DW-1:0] d, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = op;
    in_data  = d;
    for (int i = 0; i < 50; i++) begin
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    tests++;
    if ({out_valid, out_ovf, in_ready, status, level, err} !== {1'b0, 1'b0, 1'b1, 2'd0, 3'd0, 1'b0}) begin
      fails++;
      $display("FAIL reset_ctrl got v=%b ovf=%b rdy=%b st=%0d lvl=%0d err=%b", out_valid, out_ovf, in_ready, status, level, err);
    end
    tests++;
    if (out_data !== 32'h0) begin
      fails++;
      $display("FAIL reset_data got %h want 0", out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_pass();
    bit ok;
    logic [1:0] exp_st [4] = '{2'd1, 2'd1, 2'd2, 2'd0};
    out_ready = 1'b1;
    push(2'd0, 32'hDEADBEEF, ok);
    tests++;
    if (!ok || status !== 2'd0 || level !== 3'd1) begin
      fails++;
      $display("FAIL pass_accept ok=%b st=%0d lvl=%0d want st=0 lvl=1", ok, status, level);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      tests++;
      if (status !== exp_st[c] || out_valid !== (c == 2)) begin
        fails++;
        $display("FAIL pass_seq cycle %0d st=%0d v=%b want st=%0d v=%b", c + 1, status, out_valid, exp_st[c], c == 2);
      end
      if (c == 2) begin
        tests++;
        if (out_data !== 32'hDEADBEEF || out_ovf !== 1'b0) begin
          fails++;
          $display("FAIL pass_data got %h ovf=%b want deadbeef ovf=0", out_data, out_ovf);
        end
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_acc();
    bit ok;
    logic [1:0]    ops  [3] = '{2'd1, 2'd1, 2'd2};
    logic [DW-1:0] din  [3] = '{32'hFFFFFFFF, 32'h00000002, 32'h12345678};
    logic [DW-1:0] dexp [3] = '{32'hFFFFFFFF, 32'h00000001, 32'h00000000};
    logic          oexp [3] = '{1'b0, 1'b1, 1'b0};
    for (int k = 0; k < 3; k++) begin
      push(ops[k], din[k], ok);
      wait_valid(ok);
      tests++;
      if (!ok || out_data !== dexp[k] || out_ovf !== oexp[k]) begin
        fails++;
        $display("FAIL acc_step%0d ok=%b got %h ovf=%b want %h ovf=%b", k, ok, out_data, out_ovf, dexp[k], oexp[k]);
      end
      consume();
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    bit took;
    int idx;
    out_ready = 1'b0;
    for (int v = 1; v <= 5; v++) push(2'd0, DW'(v), ok);
    tests++;
    if (level !== 3'd4 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL bp_full lvl=%0d rdy=%b want lvl=4 rdy=0", level, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = 2'd0;
    in_data  = 32'd6;
    repeat (3) tick();
    tests++;
    if (level !== 3'd4 || in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'd1) begin
      fails++;
      $display("FAIL bp_stall lvl=%0d rdy=%b v=%b data=%h want lvl=4 rdy=0 v=1 data=1", level, in_ready, out_valid, out_data);
    end
    idx = 1;
    for (int c = 0; c < 200 && idx <= 6; c++) begin
      @(negedge clk);
      out_ready = 1'b1;
      if (out_valid) begin
        tests++;
        if (out_data !== DW'(idx)) begin
          fails++;
          $display("FAIL bp_order got %h want %h", out_data, DW'(idx));
        end
        idx++;
      end
      took = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (took) in_valid = 1'b0;
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    tests++;
    if (idx != 7) begin
      fails++;
      $display("FAIL bp_timeout got %0d results want 6", idx - 1);
    end
  endtask

  task automatic test_error();
    bit ok;
    push(2'd3, 32'h0, ok);
    push(2'd0, 32'h5, ok);
    tests++;
    if (status !== 2'd3 || err !== 1'b0) begin
      fails++;
      $display("FAIL err_state st=%0d err=%b want st=3 err=0", status, err);
    end
    tick();
    tests++;
    if (status !== 2'd0 || err !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL err_exit st=%0d err=%b v=%b want st=0 err=1 v=0", status, err, out_valid);
    end
    wait_valid(ok);
    tests++;
    if (!ok || out_data !== 32'h5) begin
      fails++;
      $display("FAIL err_next ok=%b got %h want 5", ok, out_data);
    end
    consume();
    repeat (6) tick();
    tests++;
    if (out_valid !== 1'b0 || level !== 3'd0 || err !== 1'b1) begin
      fails++;
      $display("FAIL err_sticky v=%b lvl=%0d err=%b want v=0 lvl=0 err=1", out_valid, level, err);
    end
    pulse_clear();
    tests++;
    if (err !== 1'b0) begin
      fails++;
      $display("FAIL err_clear got %b want 0", err);
    end
  endtask

  task automatic test_clear();
    bit ok;
    push(2'd1, 32'h10, ok);
    wait_valid(ok);
    tests++;
    if (!ok || out_data !== 32'h10) begin
      fails++;
      $display("FAIL clr_pre ok=%b got %h want 10", ok, out_data);
    end
    consume();
    push(2'd1, 32'h1, ok);
    push(2'd1, 32'h2, ok);
    push(2'd1, 32'h3, ok);
    tests++;
    if (status !== 2'd1 || level !== 3'd2) begin
      fails++;
      $display("FAIL clr_busy st=%0d lvl=%0d want st=1 lvl=2", status, level);
    end
    pulse_clear();
    tests++;
    if (level !== 3'd0 || out_valid !== 1'b0 || status !== 2'd0) begin
      fails++;
      $display("FAIL clr_flush lvl=%0d v=%b st=%0d want 0 0 0", level, out_valid, status);
    end
    push(2'd1, 32'h7, ok);
    wait_valid(ok);
    tests++;
    if (!ok || out_data !== 32'h7 || out_ovf !== 1'b0) begin
      fails++;
      $display("FAIL clr_acc ok=%b got %h ovf=%b want 7 ovf=0", ok, out_data, out_ovf);
    end
    consume();
  endtask

  task automatic test_reset_mid();
    bit ok;
    push(2'd3, 32'h0, ok);
    push(2'd0, 32'hA5, ok);
    push(2'd0, 32'h5A, ok);
    wait_valid(ok);
    tests++;
    if (!ok || err !== 1'b1 || level !== 3'd1) begin
      fails++;
      $display("FAIL rstm_pre ok=%b err=%b lvl=%0d want 1 1 1", ok, err, level);
    end
    #1;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({out_valid, out_ovf, in_ready, status, level, err} !== {1'b0, 1'b0, 1'b1, 2'd0, 3'd0, 1'b0} || out_data !== 32'h0) begin
      fails++;
      $display("FAIL rstm_async v=%b ovf=%b rdy=%b st=%0d lvl=%0d err=%b data=%h", out_valid, out_ovf, in_ready, status, level, err, out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) tick();
    tests++;
    if (out_valid !== 1'b0 || status !== 2'd0) begin
      fails++;
      $display("FAIL rstm_quiet v=%b st=%0d want v=0 st=0", out_valid, status);
    end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_acc();
    test_back_to_back();
    test_error();
    test_clear();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/custom_axi_ip_engine.md
# custom_axi_ip_engine

Parametrised, multi-entry successor to the single-shot register-to-hardware IP. It sits behind the AXI register file and accepts opcode+data commands through a valid/ready handshake. Commands are buffered in an internal FIFO and executed one at a time by an IDLE/BUSY/DONE/ERROR state machine with configurable busy latency and a running accumulator. Each result is returned through a valid/ready output handshake, and the state, FIFO level and a sticky error flag are exposed for register readback.

## Interface
- DATA_WIDTH, 32, width of data, accumulator and result (≥8)
- FIFO_DEPTH, 4, command FIFO entries (power of two, ≥2)
- OP_LATENCY, 2, cycles spent in BUSY per command (≥1)
- LVL_W, $clog2(FIFO_DEPTH+1), derived local width of level output
- clk_i  in  1  single clock, rising edge
- rst_ni  in  1  asynchronous active-low reset
- in_valid_i  in  1  command valid
- in_ready_o  out  1  command accepted when valid&&ready
- in_op_i  in  2  op_e opcode
- in_data_i  in  DATA_WIDTH  operand
- out_valid_o  out  1  result valid
- out_ready_i  in  1  result consumed when valid&&ready
- out_data_o  out  DATA_WIDTH  result
- out_ovf_o  out  1  carry-out of ACC result
- clear_i  in  1  synchronous flush/abort
- status_o  out  2  current status_e
- fifo_level_o  out  LVL_W  FIFO occupancy
- err_o  out  1  sticky illegal-opcode flag

## Operation
- Opcodes (op_e): OP_PASS=0 result=data; OP_ACC=1 acc←acc+data (mod 2^DATA_WIDTH), result=new acc, ovf=carry; OP_CLR=2 acc←0, result=0; OP_RSVD=3 illegal.
- in_ready_o = !fifo_full (combinational from registered count); accepted commands stored in order.
- IDLE: if FIFO non-empty, pop head; legal op → BUSY, busy counter=0; OP_RSVD → ERROR. Empty → stay.
- BUSY: counter increments; at counter==OP_LATENCY-1 execute op, register out_data_o/out_ovf_o/acc, set out_valid_o, → DONE.
- DONE: hold out_valid_o, out_data_o, out_ovf_o stable; on out_ready_i → clear out_valid_o, → IDLE. No FIFO pop in DONE.
- ERROR: exactly one cycle, err_o←1 (sticky), no output, accumulator untouched, → IDLE.
- status_o = registered state: IDLE=0, BUSY=1, DONE=2, ERROR=3.
- clear_i (highest priority after reset): empties FIFO, acc←0, err_o←0, out_valid_o←0, state←IDLE; a push coincident with clear_i is discarded.
- Reset: all outputs 0 except in_ready_o=1; acc=0, FIFO empty, state IDLE. Reset mid-operation drops everything immediately (asynchronous).
- Push while full: impossible (ready low). Push and pop in same cycle: level unchanged.

## Timing
- Input handshake at edge N → state BUSY after edge N+1 → out_valid_o high after edge N+1+OP_LATENCY (3 cycles for default).
- With out_ready_i held high: one result every OP_LATENCY+2 cycles (IDLE 1, BUSY OP_LATENCY, DONE 1).
- fifo_level_o updates the cycle after push/pop edge; in_ready_o falls the cycle level reaches FIFO_DEPTH.
- Illegal op costs 2 cycles (IDLE pop, ERROR).

## Structure
- custom_axi_ip_pkg: existing status_e (IDLE, BUSY, DONE, ERROR, 2-bit); add op_e (OP_PASS, OP_ACC, OP_CLR, OP_RSVD, 2-bit).
- Sub-module custom_axi_ip_fifo: synchronous FIFO, width 2+DATA_WIDTH, depth FIFO_DEPTH, push/pop/flush, full/empty/count, async active-low reset.
- Top: FSM, busy counter, accumulator, output registers, err flag.

## Test plan
- Reset asserted mid-stream → all outputs 0, in_ready_o=1, status_o=0, fifo_level_o=0 without a clock edge.
- PASS 0xDEADBEEF, out_ready_i=1 → out_valid_o 3 cycles after handshake, out_data_o=0xDEADBEEF, ovf=0; status 0→1→1→2→0.
- ACC 0xFFFFFFFF then ACC 0x00000002 → results 0xFFFFFFFF ovf=0, then 0x00000001 ovf=1; CLR → 0x0.
- out_ready_i=0, push PASS 1..6 → first popped, FIFO holds 2..5, fifo_level_o=4, in_ready_o=0, command 6 stalled; release → outputs 1..6 in order, data stable while stalled.
- OP_RSVD then PASS 0x5 → one ERROR cycle, err_o=1 sticky, single output 0x5; clear_i → err_o=0.
- Three commands queued, clear_i during BUSY → level 0, out_valid_o=0, state IDLE, next ACC 0x7 returns 0x7.
